ram_access_controller: RTL and testbench
========================================

RAM_ACCESS_CONTROLLER -- requirements
Module: ram_access_controller

Interface
REQ-001 Parameters SHALL be: DATA_W, default 64, data word width; ADDR_W, default 11, RAM address width; MAX_BURST, default 4, maximum beats per request.
REQ-002 Ports, clock and reset first: clk  in  1  single clock, all logic on rising edge; reset  in  1  synchronous, active-high.
REQ-003 req_valid  in  1  request offered; req_ready  out  1  controller accepts request.
REQ-004 req_write  in  1  1 = write burst, 0 = read burst; req_addr  in  ADDR_W  start address; req_len  in  2  beats minus 1 (0..3).
REQ-005 wdata_valid  in  1  write beat offered; wdata_ready  out  1  beat accepted; wdata  in  DATA_W  write beat.
REQ-006 rdata_valid  out  1  read beat held; rdata_ready  in  1  consumer takes beat; rdata  out  DATA_W  read beat.
REQ-007 done  out  1  one-cycle pulse after the final beat of a burst.
REQ-008 ram_address  out  ADDR_W; ram_isReading  out  1; ram_dataIn  out  DATA_W; ram_dataOut  in  DATA_W (these connect to RAM ports address, isReading, dataIn, dataOut).

Function
REQ-009 The RAM SHALL be treated as writing dataIn to address on every rising clk edge where isReading=0, and presenting dataOut for the address sampled on the previous edge (1-cycle read latency).
REQ-010 ram_isReading SHALL be 1 in every cycle except a write-beat cycle; no other cycle may write RAM.
REQ-011 FSM states SHALL be IDLE, WRITE, RD_ADDR, RD_CAP, RD_HOLD.
REQ-012 IDLE: req_ready=1; on req_valid&req_ready, latch addr, len, write flag; go to WRITE if req_write else RD_ADDR.
REQ-013 WRITE: wdata_ready=1; on wdata_valid, drive ram_address=current addr, ram_dataIn=wdata, ram_isReading=0 combinationally in that cycle; advance addr and beat count on the edge.
REQ-014 WRITE with wdata_valid=0 SHALL hold state, ram_isReading=1, no RAM write.
REQ-015 RD_ADDR: drive ram_address=current addr, ram_isReading=1; next state RD_CAP.
REQ-016 RD_CAP: register ram_dataOut into rdata hold register; next state RD_HOLD.
REQ-017 RD_HOLD: rdata_valid=1, rdata stable until rdata_ready; on rdata_ready advance addr/count, go RD_ADDR, or IDLE if last beat.
REQ-018 Read throughput SHALL be at most one beat per 3 cycles; write throughput one beat per cycle.
REQ-019 Address SHALL increment by 1 per beat modulo 2^ADDR_W (2047 wraps to 0).
REQ-020 Burst length SHALL be req_len+1; after final beat state returns to IDLE and done=1 for exactly that next cycle.
REQ-021 req_ready SHALL be 0 outside IDLE; a new request is accepted no earlier than the cycle done is high.
REQ-022 wdata_ready=0 and rdata_valid=0 in all states other than WRITE and RD_HOLD respectively.

Reset
REQ-023 On reset: state IDLE, req_ready=1, wdata_ready=0, rdata_valid=0, rdata=0, done=0, ram_isReading=1, ram_address=0, ram_dataIn=0.
REQ-024 Reset mid-burst SHALL abort the burst; ram_isReading=1 from the reset cycle; beats already written remain; no done pulse.

Structure
REQ-025 State encoding, DATA_W/ADDR_W defaults and MAX_BURST SHALL live in a shared package ram_pkg.
REQ-026 The address/beat counter SHALL be a sub-module burst_counter (load, increment, wrap, last flag).

Verification
REQ-027 Write 1 beat 0xff04 at 1024, then read 1 beat at 1024 -> rdata=0xff04, done pulses after each burst.
REQ-028 Read at 1023 (never written) after writing 1024 -> rdata=RAM content of 1023 (0 after init), 1024 unchanged.
REQ-029 Write 4 beats at 2046 with data 1,2,3,4 -> addresses 2046,2047,0,1 hold 1,2,3,4; read-back burst matches.
REQ-030 Read burst with rdata_ready low 5 cycles per beat -> rdata held stable, ram_isReading=1 throughout.
REQ-031 Write burst with wdata_valid gaps -> exactly 4 cycles with ram_isReading=0, count of RAM writes = 4.
REQ-032 Assert reset during beat 2 of a 4-beat write -> only beats 0-1 written, outputs at reset values next cycle, no done.

Source files
------------

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_pkg
//  Description : Shared constants and FSM state encoding for the RAM access
//                controller and its burst counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

  localparam int DATA_W_DEFAULT = 64;
  localparam int ADDR_W_DEFAULT = 11;
  localparam int MAX_BURST_DEFAULT = 4;

  // Requests carry beats-minus-one in a two-bit field.
  localparam int REQ_LEN_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_CAP  = 3'd3,
    ST_RD_HOLD = 3'd4
  } state_t;

endpackage : ram_pkg
`default_nettype wire

// File: rtl/burst_counter.sv
`default_nettype none
// ============================================================================
//  Module      : burst_counter
//  Description : Address and remaining-beat counter for one burst. Loads the
//                start address and beats-minus-one, increments the address
//                (wrapping modulo 2^ADDR_W) and flags the final beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module burst_counter #(
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [CNT_W-1:0]  load_len,
  input  logic              incr,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [CNT_W-1:0] remaining;

  // Load takes priority; increment advances address and consumes one beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= load_len;
    end else if (incr) begin
      addr      <= addr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

  assign last = (remaining == '0);

endmodule : burst_counter
`default_nettype wire

// File: rtl/ram_access_controller.sv
`default_nettype none
// ============================================================================
//  Module      : ram_access_controller
//  Description : Burst read/write front end for a single-port synchronous RAM
//                with one-cycle read latency. Writes stream one beat per
//                cycle; reads take address, capture and hold phases per beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_access_controller
  import ram_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [REQ_LEN_W-1:0] req_len,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  input  logic [DATA_W-1:0]    wdata,
  output logic                 rdata_valid,
  input  logic                 rdata_ready,
  output logic [DATA_W-1:0]    rdata,
  output logic                 done,
  output logic [ADDR_W-1:0]    ram_address,
  output logic                 ram_isReading,
  output logic [DATA_W-1:0]    ram_dataIn,
  input  logic [DATA_W-1:0]    ram_dataOut
);

  localparam int CNT_W = $clog2(MAX_BURST);

  state_t            state;
  state_t            state_next;
  logic              cnt_load;
  logic              cnt_incr;
  logic              done_next;
  logic              last_beat;
  logic              write_beat;
  logic [ADDR_W-1:0] cur_addr;

  burst_counter #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_burst_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (cnt_load),
    .load_addr (req_addr),
    .load_len  (CNT_W'(req_len)),
    .incr      (cnt_incr),
    .addr      (cur_addr),
    .last      (last_beat)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode, counter control and end-of-burst detection.
  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_incr   = 1'b0;
    done_next  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          cnt_load   = 1'b1;
          state_next = req_write ? ST_WRITE : ST_RD_ADDR;
        end
      end
      ST_WRITE: begin
        if (wdata_valid) begin
          cnt_incr = 1'b1;
          if (last_beat) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      ST_RD_ADDR: state_next = ST_RD_CAP;
      ST_RD_CAP:  state_next = ST_RD_HOLD;
      ST_RD_HOLD: begin
        if (rdata_ready) begin
          cnt_incr = 1'b1;
          if (last_beat) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = ST_RD_ADDR;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Read hold register and the one-cycle completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
      done  <= 1'b0;
    end else begin
      if (state == ST_RD_CAP) begin
        rdata <= ram_dataOut;
      end
      done <= done_next;
    end
  end

  // A write beat is suppressed while reset is asserted so an aborted burst
  // cannot touch the RAM in the reset cycle itself.
  assign write_beat    = (state == ST_WRITE) && wdata_valid && !reset;

  assign req_ready     = (state == ST_IDLE);
  assign wdata_ready   = (state == ST_WRITE) && !reset;
  assign rdata_valid   = (state == ST_RD_HOLD);
  assign ram_isReading = !write_beat;
  assign ram_dataIn    = write_beat ? wdata : '0;
  assign ram_address   = (write_beat || (state == ST_RD_ADDR)) ? cur_addr : '0;

endmodule : ram_access_controller
`default_nettype wire

// File: tb/tb_ram_access_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_access_controller
//  Description : Self-checking bench: directed vector table, multi-cycle
//                corner sequences and random bursts against an array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_access_controller;

  localparam int DW = 64;
  localparam int AW = 11;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_len;
  logic          wdata_valid;
  logic          wdata_ready;
  logic [DW-1:0] wdata;
  logic          rdata_valid;
  logic          rdata_ready;
  logic [DW-1:0] rdata;
  logic          done;
  logic [AW-1:0] ram_address;
  logic          ram_isReading;
  logic [DW-1:0] ram_dataIn;
  logic [DW-1:0] ram_dataOut;

  int total = 0;
  int bad   = 0;
  int ram_writes = 0;

  logic [DW-1:0] ram_mem   [DEPTH];
  logic [DW-1:0] model_mem [DEPTH];

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [1:0]    len;
    logic [3:0][DW-1:0] data;
  } vec_t;

  vec_t tbl [6];

  ram_access_controller dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_len       (req_len),
    .wdata_valid   (wdata_valid),
    .wdata_ready   (wdata_ready),
    .wdata         (wdata),
    .rdata_valid   (rdata_valid),
    .rdata_ready   (rdata_ready),
    .rdata         (rdata),
    .done          (done),
    .ram_address   (ram_address),
    .ram_isReading (ram_isReading),
    .ram_dataIn    (ram_dataIn),
    .ram_dataOut   (ram_dataOut)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: write when not reading, registered read data.
  always @(posedge clk) begin
    if (!ram_isReading) ram_mem[ram_address] <= ram_dataIn;
    ram_dataOut <= ram_mem[ram_address];
  end

  // Independent count of RAM write edges.
  always @(posedge clk) begin
    if (!ram_isReading) ram_writes <= ram_writes + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"},   req_ready, 1);
    check({tag, "_wdata_ready"}, wdata_ready, 0);
    check({tag, "_rdata_valid"}, rdata_valid, 0);
    check({tag, "_rdata"},       rdata, 0);
    check({tag, "_done"},        done, 0);
    check({tag, "_isReading"},   ram_isReading, 1);
    check({tag, "_address"},     ram_address, 0);
    check({tag, "_dataIn"},      ram_dataIn, 0);
  endtask

  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [1:0] len);
    int w = 0;
    while (!req_ready && w < 20) begin
      tick();
      w++;
    end
    check("req_ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_len   = len;
    tick();
    req_valid = 1'b0;
    check("req_ready_busy", req_ready, 0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [1:0] len,
                          input logic [3:0][DW-1:0] d, input int gap);
    logic [AW-1:0] cur;
    cur = a;
    issue(1'b1, a, len);
    for (int b = 0; b <= int'(len); b++) begin
      for (int k = 0; k < gap; k++) begin
        wdata_valid = 1'b0;
        #1;
        check("wr_gap_isReading", ram_isReading, 1);
        check("wr_gap_ready", wdata_ready, 1);
        tick();
      end
      wdata_valid = 1'b1;
      wdata = d[b];
      #1;
      check("wr_ready", wdata_ready, 1);
      check("wr_isReading", ram_isReading, 0);
      check("wr_addr", ram_address, cur);
      check("wr_dataIn", ram_dataIn, d[b]);
      tick();
      model_mem[cur] = d[b];
      cur = cur + 1'b1;
    end
    wdata_valid = 1'b0;
    check("wr_done", done, 1);
    check("wr_idle_ready", req_ready, 1);
    tick();
    check("wr_done_once", done, 0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [1:0] len,
                         input logic [3:0][DW-1:0] exp, input int stall);
    logic [AW-1:0] cur;
    logic [DW-1:0] held;
    cur = a;
    issue(1'b0, a, len);
    for (int b = 0; b <= int'(len); b++) begin
      int w = 0;
      rdata_ready = 1'b0;
      while (!rdata_valid && w < 10) begin
        check("rd_wait_isReading", ram_isReading, 1);
        if (w == 0) check("rd_addr", ram_address, cur);
        tick();
        w++;
      end
      check("rd_valid", rdata_valid, 1);
      check("rd_latency", w, 2);
      held = rdata;
      for (int k = 0; k < stall; k++) begin
        tick();
        check("rd_hold_valid", rdata_valid, 1);
        check("rd_hold_stable", rdata, held);
        check("rd_hold_isReading", ram_isReading, 1);
      end
      check("rd_data", rdata, exp[b]);
      rdata_ready = 1'b1;
      tick();
      rdata_ready = 1'b0;
      cur = cur + 1'b1;
    end
    check("rd_done", done, 1);
    check("rd_valid_low", rdata_valid, 0);
    tick();
    check("rd_done_once", done, 0);
  endtask

  task automatic set_vec(input int i, input bit wr, input logic [AW-1:0] a, input logic [1:0] len,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    tbl[i].wr      = wr;
    tbl[i].addr    = a;
    tbl[i].len     = len;
    tbl[i].data[0] = d0;
    tbl[i].data[1] = d1;
    tbl[i].data[2] = d2;
    tbl[i].data[3] = d3;
  endtask

  function automatic logic [3:0][DW-1:0] model_read(input logic [AW-1:0] a);
    logic [3:0][DW-1:0] r;
    logic [AW-1:0] ad;
    for (int b = 0; b < 4; b++) begin
      ad = a + AW'(b);
      r[b] = model_mem[ad];
    end
    return r;
  endfunction

  initial begin
    logic [3:0][DW-1:0] d;
    int w0;

    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i]   = '0;
      model_mem[i] = '0;
    end

    // Directed vectors: writes carry data, reads carry expected data.
    set_vec(0, 1'b1, 11'd1024, 2'd0, 64'hff04, 0, 0, 0);
    set_vec(1, 1'b0, 11'd1024, 2'd0, 64'hff04, 0, 0, 0);
    set_vec(2, 1'b0, 11'd1023, 2'd0, 64'h0,    0, 0, 0);
    set_vec(3, 1'b0, 11'd1024, 2'd0, 64'hff04, 0, 0, 0);
    set_vec(4, 1'b1, 11'd2046, 2'd3, 64'd1, 64'd2, 64'd3, 64'd4);
    set_vec(5, 1'b0, 11'd2046, 2'd3, 64'd1, 64'd2, 64'd3, 64'd4);

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
    tick(); tick(); tick();
    check_reset_values("rst");
    reset = 1'b0;
    tick();
    check_reset_values("post_rst");

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].len, tbl[i].data, 0);
      else           do_read(tbl[i].addr, tbl[i].len, tbl[i].data, 0);
    end
    check("wrap_ram_2047", ram_mem[2047], 64'd2);
    check("wrap_ram_0",    ram_mem[0],    64'd3);
    check("wrap_ram_1",    ram_mem[1],    64'd4);

    // Long consumer stalls on a read burst.
    do_read(11'd2046, 2'd3, model_read(11'd2046), 5);

    // Write burst with gaps: exactly four RAM write edges.
    d[0] = 64'hA1; d[1] = 64'hB2; d[2] = 64'hC3; d[3] = 64'hD4;
    w0 = ram_writes;
    do_write(11'd500, 2'd3, d, 2);
    check("gap_write_count", ram_writes - w0, 4);
    do_read(11'd500, 2'd3, model_read(11'd500), 0);

    // Reset during beat 2 of a 4-beat write.
    d[0] = 64'h1111; d[1] = 64'h2222; d[2] = 64'h3333; d[3] = 64'h4444;
    w0 = ram_writes;
    issue(1'b1, 11'd300, 2'd3);
    for (int b = 0; b < 2; b++) begin
      wdata_valid = 1'b1;
      wdata = d[b];
      tick();
      model_mem[11'd300 + AW'(b)] = d[b];
    end
    wdata_valid = 1'b1;
    wdata = d[2];
    reset = 1'b1;
    #1;
    check("abort_isReading_in_reset", ram_isReading, 1);
    tick();
    reset = 1'b0;
    wdata_valid = 1'b0;
    #1;
    check_reset_values("abort");
    tick();
    check("abort_no_done", done, 0);
    check("abort_write_count", ram_writes - w0, 2);
    do_read(11'd300, 2'd3, model_read(11'd300), 1);

    // Random bursts against the array model.
    for (int n = 0; n < 30; n++) begin
      logic [AW-1:0] a;
      logic [1:0] len;
      a   = AW'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 3) == 0) a = AW'(2045 + $urandom_range(0, 2));
      len = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < 4; b++) d[b] = {$urandom(), $urandom()};
        do_write(a, len, d, int'($urandom_range(0, 2)));
      end else begin
        do_read(a, len, model_read(a), int'($urandom_range(0, 2)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ram_access_controller
`default_nettype wire
